// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use detection, multi-cycle stall sequencing,
// memory-busy freeze, taken-branch flush and saturating stall/flush counters.
module hazard_stall_ctrl #(
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_reg_write,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StMemWait = 2'd2
  } state_e;

  localparam logic [3:0] LuReload = 4'(LOAD_USE_CYCLES - 1);

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  state_e           eff_state;
  logic [3:0]       lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             lu;

  assign lu = ex_is_load && ex_reg_write && (ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_bubble = 1'b0;
    state_d     = StRun;
    ret_d       = ret_q;
    lu_cnt_d    = lu_cnt_q;

    // Leaving MEM_WAIT behaves exactly like the saved state; illegal code acts as RUN.
    case (state_q)
      StLuStall: eff_state = StLuStall;
      StMemWait: eff_state = ret_q;
      default:   eff_state = StRun;
    endcase

    if (mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_hold  = 1'b1;
      state_d    = StMemWait;
      if (state_q != StMemWait) ret_d = eff_state;
    end else if (br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      lu_cnt_d    = 4'd0;
    end else if (eff_state == StLuStall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      if (lu_cnt_q <= 4'd1) begin
        lu_cnt_d = 4'd0;
      end else begin
        lu_cnt_d = lu_cnt_q - 4'd1;
        state_d  = StLuStall;
      end
    end else if (lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      if (LOAD_USE_CYCLES > 1) begin
        lu_cnt_d = LuReload;
        state_d  = StLuStall;
      end
    end

    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_hold   = 1'b0;
      idex_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      ret_q       <= StRun;
      lu_cnt_q    <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      lu_cnt_q <= lu_cnt_d;
      if (!pc_write && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: three instances (1-cycle, 3-cycle, 4-bit counters)
// share one stimulus bus; each sequence resets and checks the relevant instance.
module tb_hazard_stall_ctrl;

  logic       clk, rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_is_load, ex_reg_write, br_taken, mem_busy;

  logic        a_pc_write, a_ifid_write, a_ifid_flush, a_idex_hold, a_idex_bubble;
  logic [1:0]  a_state;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        b_pc_write, b_ifid_write, b_ifid_flush, b_idex_hold, b_idex_bubble;
  logic [1:0]  b_state;
  logic [15:0] b_stall_cnt, b_flush_cnt;
  logic        c_pc_write, c_ifid_write, c_ifid_flush, c_idex_hold, c_idex_bubble;
  logic [1:0]  c_state;
  logic [3:0]  c_stall_cnt, c_flush_cnt;

  hazard_stall_ctrl #(.LOAD_USE_CYCLES(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write),
    .br_taken(br_taken), .mem_busy(mem_busy), .pc_write(a_pc_write), .ifid_write(a_ifid_write),
    .ifid_flush(a_ifid_flush), .idex_hold(a_idex_hold), .idex_bubble(a_idex_bubble),
    .state(a_state), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  hazard_stall_ctrl #(.LOAD_USE_CYCLES(3), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write),
    .br_taken(br_taken), .mem_busy(mem_busy), .pc_write(b_pc_write), .ifid_write(b_ifid_write),
    .ifid_flush(b_ifid_flush), .idex_hold(b_idex_hold), .idex_bubble(b_idex_bubble),
    .state(b_state), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  hazard_stall_ctrl #(.LOAD_USE_CYCLES(1), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write),
    .br_taken(br_taken), .mem_busy(mem_busy), .pc_write(c_pc_write), .ifid_write(c_ifid_write),
    .ifid_flush(c_ifid_flush), .idex_hold(c_idex_hold), .idex_bubble(c_idex_bubble),
    .state(c_state), .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // exp_out packs {pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble}
  typedef struct {
    string       name;
    logic [4:0]  rs1, rs2;
    logic        use1, use2;
    logic [4:0]  rd;
    logic        ld, rw, br, mb;
    logic [4:0]  exp_out;
    logic [1:0]  exp_state;
    logic [15:0] exp_stall, exp_flush;
  } vec_t;

  vec_t vecs[10];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_reg_write = 1'b0; br_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic hazard();
    idle();
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] a_outs();
    return 32'({a_pc_write, a_ifid_write, a_ifid_flush, a_idex_hold, a_idex_bubble});
  endfunction

  initial begin
    vecs[0] = '{"idle",     5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                5'b11000, 2'd0, 16'd0, 16'd0};
    vecs[1] = '{"lu_rs2",   5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0,
                5'b00001, 2'd0, 16'd1, 16'd0};
    vecs[2] = '{"rd_zero",  5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0,
                5'b11000, 2'd0, 16'd0, 16'd0};
    vecs[3] = '{"no_use",   5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0,
                5'b11000, 2'd0, 16'd0, 16'd0};
    vecs[4] = '{"not_load", 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0,
                5'b11000, 2'd0, 16'd0, 16'd0};
    vecs[5] = '{"no_rw",    5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0,
                5'b11000, 2'd0, 16'd0, 16'd0};
    vecs[6] = '{"lu_rs1",   5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0,
                5'b00001, 2'd0, 16'd1, 16'd0};
    vecs[7] = '{"br_lu",    5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0,
                5'b11101, 2'd0, 16'd0, 16'd1};
    vecs[8] = '{"mb_all",   5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1,
                5'b00010, 2'd2, 16'd1, 16'd0};
    vecs[9] = '{"br_only",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                5'b11101, 2'd0, 16'd0, 16'd1};

    // Reset: outputs forced low while rst is high, run outputs afterwards
    idle();
    rst = 1'b1;
    #1;
    check("rst_forced_outs", a_outs(), 32'b00000);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_state", 32'(a_state), 32'd0);
    check("reset_outs", a_outs(), 32'b11000);
    check("reset_stall_cnt", 32'(a_stall_cnt), 32'd0);
    check("reset_flush_cnt", 32'(a_flush_cnt), 32'd0);

    // Single-cycle vectors on the LOAD_USE_CYCLES=1 instance
    for (int i = 0; i < 10; i++) begin
      do_reset();
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_use_rs1 = vecs[i].use1; id_use_rs2 = vecs[i].use2;
      ex_rd = vecs[i].rd; ex_is_load = vecs[i].ld; ex_reg_write = vecs[i].rw;
      br_taken = vecs[i].br; mem_busy = vecs[i].mb;
      #1;
      check({vecs[i].name, "_outs"}, a_outs(), 32'(vecs[i].exp_out));
      tick();
      idle();
      #1;
      check({vecs[i].name, "_next_state"}, 32'(a_state), 32'(vecs[i].exp_state));
      check({vecs[i].name, "_stall_cnt"}, 32'(a_stall_cnt), 32'(vecs[i].exp_stall));
      check({vecs[i].name, "_flush_cnt"}, 32'(a_flush_cnt), 32'(vecs[i].exp_flush));
      check({vecs[i].name, "_then_run"}, 32'(a_pc_write), 32'd1);
    end

    // Three-cycle load-use: states 0,1,1,0
    do_reset();
    hazard();
    #1;
    check("lu3_c0_state", 32'(b_state), 32'd0);
    check("lu3_c0_stall", 32'({b_pc_write, b_idex_bubble}), 32'b01);
    tick();
    idle();
    #1;
    check("lu3_c1_state", 32'(b_state), 32'd1);
    check("lu3_c1_stall", 32'({b_pc_write, b_idex_bubble}), 32'b01);
    tick();
    #1;
    check("lu3_c2_state", 32'(b_state), 32'd1);
    check("lu3_c2_stall", 32'({b_pc_write, b_idex_bubble}), 32'b01);
    tick();
    #1;
    check("lu3_c3_state", 32'(b_state), 32'd0);
    check("lu3_c3_pc_write", 32'(b_pc_write), 32'd1);
    check("lu3_stall_cnt", 32'(b_stall_cnt), 32'd3);

    // Memory freeze during the second stall cycle extends the stall one for one
    do_reset();
    hazard();
    tick();
    idle();
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("frz_hold", 32'({b_pc_write, b_idex_hold, b_idex_bubble}), 32'b010);
      tick();
    end
    mem_busy = 1'b0;
    #1;
    check("frz_resume_state", 32'(b_state), 32'd2);
    check("frz_resume_stall", 32'({b_pc_write, b_idex_hold, b_idex_bubble}), 32'b001);
    tick();
    #1;
    check("frz_last_state", 32'(b_state), 32'd1);
    check("frz_last_stall", 32'({b_pc_write, b_idex_hold, b_idex_bubble}), 32'b001);
    tick();
    #1;
    check("frz_done_state", 32'(b_state), 32'd0);
    check("frz_done_pc_write", 32'(b_pc_write), 32'd1);
    check("frz_stall_cnt", 32'(b_stall_cnt), 32'd7);

    // Branch together with a hazard: flush wins, no stall recorded
    do_reset();
    hazard();
    br_taken = 1'b1;
    #1;
    check("brlu_outs", 32'({b_pc_write, b_ifid_flush, b_idex_hold, b_idex_bubble}), 32'b1101);
    tick();
    idle();
    #1;
    check("brlu_state", 32'(b_state), 32'd0);
    check("brlu_flush_cnt", 32'(b_flush_cnt), 32'd1);
    check("brlu_stall_cnt", 32'(b_stall_cnt), 32'd0);

    // Branch inside LU_STALL aborts the remaining stall
    do_reset();
    hazard();
    tick();
    idle();
    br_taken = 1'b1;
    #1;
    check("brstall_outs", 32'({b_pc_write, b_ifid_flush, b_idex_bubble}), 32'b111);
    tick();
    idle();
    #1;
    check("brstall_state", 32'(b_state), 32'd0);
    check("brstall_pc_write", 32'(b_pc_write), 32'd1);
    check("brstall_stall_cnt", 32'(b_stall_cnt), 32'd1);

    // Saturation on 4-bit counters, then reset while in MEM_WAIT
    do_reset();
    mem_busy = 1'b1;
    repeat (20) tick();
    #1;
    check("sat_stall_cnt", 32'(c_stall_cnt), 32'd15);
    check("sat_state", 32'(c_state), 32'd2);
    rst = 1'b1;
    #1;
    check("sat_rst_forced", 32'({c_pc_write, c_ifid_write, c_idex_hold}), 32'b000);
    tick();
    rst = 1'b0;
    mem_busy = 1'b0;
    #1;
    check("sat_rst_state", 32'(c_state), 32'd0);
    check("sat_rst_stall_cnt", 32'(c_stall_cnt), 32'd0);
    check("sat_rst_flush_cnt", 32'(c_flush_cnt), 32'd0);
    check("sat_rst_pc_write", 32'(c_pc_write), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
